matmul_sched: RTL
=================

# matmul_sched

Sequencer that computes a 3x3 matrix product C = A x B by time-multiplexing one shared `mac` unit. It replaces the nine-MAC wavefront arrangement where area matters more than latency. The block snapshots both operand matrices on `start` and issues the 27 multiply-accumulate operations in row-major output order, with an explicit Load/Done handshake per operation. It drives the 3x3 result registers and sits between the matrix front-end and a single `mac` instance.

## Interface
- `W`, default 8: element width; all arithmetic is modulo 2^W.
- `N`, default 3: matrix dimension. Only 3 is verified.
- `clk`, input, 1: clock.
- `Reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a multiply. Sampled only in IDLE.
- `a_flat`, input, N\*N\*W: matrix A, row-major, element [r][c] at bits `(r*N+c)*W +: W`.
- `b_flat`, input, N\*N\*W: matrix B, same packing as A.
- `out_flat`, output, N\*N\*W: result matrix C, same packing.
- `busy`, output, 1: high from the cycle after `start` is accepted until FINISH is left.
- `done`, output, 1: one-cycle pulse in FINISH.
- `mac_load`, output, 1: one-cycle request to the MAC.
- `mac_ain`, output, W: addend presented to the MAC.
- `mac_b`, output, W: multiplicand (A element).
- `mac_c`, output, W: multiplier (B element).
- `mac_done`, input, 1: MAC idle / result valid.
- `mac_aout`, input, W: MAC result, ain + b\*c mod 2^W.

## Operation
- **Reset values:** state IDLE; `busy`=0, `done`=0, `mac_load`=0, `mac_ain`/`mac_b`/`mac_c`=0, `out_flat`=0, counters i/j/k=0, partial=0.
- **IDLE:** on `start`, latch `a_flat` and `b_flat` into snapshot registers, clear i/j/k, and go to ISSUE. Operand changes after acceptance have no effect.
- **ISSUE:** wait for `mac_done`=1. Then pulse `mac_load` with `mac_b`=A[i][k], `mac_c`=B[k][j], and `mac_ain`=0 if k=0, otherwise partial. Go to GUARD.
- **GUARD:** one cycle in which `mac_done` is ignored. This covers MACs that drop Done one cycle after Load. Go to WAIT.
- **WAIT:** on `mac_done`=1:
  - Update partial from `mac_aout`.
  - If k<N-1: increment k and go to ISSUE.
  - Otherwise: write `mac_aout` to out[i][j] and clear k. Advance j, wrapping to 0 and incrementing i. If i=j=N-1 go to FINISH, else go to ISSUE.
- **FINISH:** `done`=1 for one cycle, then go to IDLE. `out_flat` holds until the next accepted `start` completes its first element write. Elements are overwritten individually; the register is not cleared at start.
- **Ignored inputs:** `start` while busy is ignored and not queued. `start` held high in FINISH's following IDLE cycle begins a new run.
- **Reset mid-operation:** takes effect on that edge. Returns to IDLE with all reset values, including `out_flat`=0. `mac_load` is never asserted in the cycle after Reset.
- **Overflow:** sums and products wrap modulo 2^W, with no saturation or flag.

## Timing
- With a MAC returning `mac_done`=1 two cycles after Load, each product takes 3 cycles (ISSUE, GUARD, WAIT).
- For `start` accepted at edge 0:
  - First `mac_load` at cycle 1.
  - `out[0][0]` written at cycle 9.
  - Last WAIT at cycle 81.
  - `done` at cycle 82.
  - `busy` falls at cycle 83.
- MAC latency L≥2 adds L-2 cycles per product.
- `out_flat` elements update on the WAIT edge and are registered.

## Configuration
- **`MATMUL_SCHED_SKIPZERO_EN`**
  - **Defined:** in ISSUE, if A[i][k]=0 or B[k][j]=0, no `mac_load` is issued. Partial is kept unchanged (or set to 0 when k=0) and k advances in that one cycle. If this is the last k, out[i][j] is written in that same cycle.
  - **Undefined:** all 27 operations are always issued.
  - Results are identical in both configurations; only the cycle count differs.

## Structure
- **Package `matmul_pkg`:** state enum (IDLE, ISSUE, GUARD, WAIT, FINISH), default W/N localparams, and an index function `idx(r,c)` returning r\*N+c.
- **Sub-module `matmul_opsel`:** combinational mux selecting A[i][k], B[k][j], and the out write-enable from the snapshots and counters.
- The `mac` itself stays outside this block.

## Test plan
- **Identity:** A=identity, B=1..9 row-major → `out_flat`=1..9. `done` at cycle 82 with a 2-cycle MAC model.
- **All twos:** A=B=all 2 → every out element = 12. Exactly 27 `mac_load` pulses.
- **Wrap-around:** A=B=all 16 → every element = 768 mod 256 = 0. A=all 255, B=all 1 → every element = 765 mod 256 = 253.
- **Reset mid-operation:** Reset at cycle 40 → next cycle `busy`=0, `out_flat`=0, `mac_load`=0. A fresh `start` then gives a correct result.
- **Start while busy and input changes:** `start` pulsed at cycle 20 with different A → ignored, and the result matches the first snapshot. Back-to-back `start` after FINISH is accepted.
- **`MATMUL_SCHED_SKIPZERO_EN` defined:** A=identity, B=all 3 → out all 3. Exactly 9 `mac_load` pulses, and `done` occurs earlier than in the undefined build.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types for the 3x3 matrix-multiply sequencer: FSM states, default sizes,
// and the row-major element index helper.
package matmul_pkg;

  localparam int MM_W = 8;
  localparam int MM_N = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    FINISH
  } state_e;

  function automatic int idx(input int r, input int c, input int n = MM_N);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matmul_opsel.sv
// Operand/result selector: picks A[i][k] and B[k][j] from the snapshots and decodes
// the out[i][j] write strobe. Purely combinational, no flow control.
module matmul_opsel
  import matmul_pkg::*;
#(
  parameter int W  = MM_W,
  parameter int N  = MM_N,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*N*W-1:0] a_snap,
  input  logic [N*N*W-1:0] b_snap,
  input  logic [CW-1:0]    i,
  input  logic [CW-1:0]    j,
  input  logic [CW-1:0]    k,
  input  logic             wr_en,
  output logic [W-1:0]     a_el,
  output logic [W-1:0]     b_el,
  output logic [N*N-1:0]   out_we
);

  // Loop-based mux keeps every part-select base a constant.
  always_comb begin
    a_el = '0;
    b_el = '0;
    for (int e = 0; e < N * N; e++) begin
      if (idx(int'(i), int'(k), N) == e) a_el = a_snap[e*W +: W];
      if (idx(int'(k), int'(j), N) == e) b_el = b_snap[e*W +: W];
    end
  end

  // Kept separate from the operand mux so the strobe path has no false loop.
  always_comb begin
    out_we = '0;
    for (int e = 0; e < N * N; e++) begin
      out_we[e] = wr_en && (idx(int'(i), int'(j), N) == e);
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// C = A x B through one shared MAC; 3 cycles/product with a 2-cycle MAC (done at 82), stalls on mac_done.
// Optional `MATMUL_SCHED_SKIPZERO_EN: products with a zero operand are skipped in a single ISSUE cycle.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int W = MM_W,
  parameter int N = MM_N
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic [N*N*W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic             mac_load,
  output logic [W-1:0]     mac_ain,
  output logic [W-1:0]     mac_b,
  output logic [W-1:0]     mac_c,
  input  logic             mac_done,
  input  logic [W-1:0]     mac_aout
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e             state_q, state_d;
  logic [N*N*W-1:0]   a_snap_q, a_snap_d;
  logic [N*N*W-1:0]   b_snap_q, b_snap_d;
  logic [N*N*W-1:0]   out_q, out_d;
  logic [CW-1:0]      i_q, i_d;
  logic [CW-1:0]      j_q, j_d;
  logic [CW-1:0]      k_q, k_d;
  logic [W-1:0]       partial_q, partial_d;

  logic [W-1:0]       a_el;
  logic [W-1:0]       b_el;
  logic [N*N-1:0]     out_we;
  logic               wr_en;
  logic [W-1:0]       wr_val;
  logic               step;
  logic               skip;

  matmul_opsel #(
    .W  (W),
    .N  (N),
    .CW (CW)
  ) u_opsel (
    .a_snap (a_snap_q),
    .b_snap (b_snap_q),
    .i      (i_q),
    .j      (j_q),
    .k      (k_q),
    .wr_en  (wr_en),
    .a_el   (a_el),
    .b_el   (b_el),
    .out_we (out_we)
  );

  always_comb begin
    state_d   = state_q;
    a_snap_d  = a_snap_q;
    b_snap_d  = b_snap_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    partial_d = partial_q;
    wr_en     = 1'b0;
    wr_val    = mac_aout;
    step      = 1'b0;
    mac_load  = 1'b0;
    mac_ain   = '0;
    mac_b     = '0;
    mac_c     = '0;
    done      = 1'b0;
    skip      = 1'b0;
`ifdef MATMUL_SCHED_SKIPZERO_EN
    skip = (state_q == ISSUE) && ((a_el == '0) || (b_el == '0));
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_snap_d = a_flat;
          b_snap_d = b_flat;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (skip) begin
          // A zero product leaves the running sum untouched; k=0 starts it at zero.
          partial_d = (k_q == '0) ? '0 : partial_q;
          wr_val    = partial_d;
          step      = 1'b1;
        end else if (mac_done) begin
          mac_load = 1'b1;
          mac_b    = a_el;
          mac_c    = b_el;
          mac_ain  = (k_q == '0) ? '0 : partial_q;
          state_d  = GUARD;
        end
      end
      // MACs may still show the previous Done for one cycle after Load.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (mac_done) begin
          partial_d = mac_aout;
          wr_val    = mac_aout;
          step      = 1'b1;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      if (k_q != LAST) begin
        k_d     = k_q + ONE;
        state_d = ISSUE;
      end else begin
        wr_en = 1'b1;
        k_d   = '0;
        if ((i_q == LAST) && (j_q == LAST)) begin
          i_d     = '0;
          j_d     = '0;
          state_d = FINISH;
        end else begin
          state_d = ISSUE;
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + ONE;
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
    end
  end

  always_comb begin
    out_d = out_q;
    for (int e = 0; e < N * N; e++) begin
      if (out_we[e]) out_d[e*W +: W] = wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      a_snap_q  <= '0;
      b_snap_q  <= '0;
      out_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      partial_q <= '0;
    end else begin
      state_q   <= state_d;
      a_snap_q  <= a_snap_d;
      b_snap_q  <= b_snap_d;
      out_q     <= out_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      partial_q <= partial_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign out_flat = out_q;

endmodule
